// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SDRAM word-port arbiter.
package mem_arb_pkg;

    localparam int unsigned NPORTS = 3;
    localparam int unsigned AW     = 24;
    localparam int unsigned DW     = 16;
    localparam int unsigned BW     = 2;

    localparam int unsigned P_CPU  = 0;
    localparam int unsigned P_COPY = 1;
    localparam int unsigned P_DMA  = 2;

    localparam logic [DW-1:0] DOUT_TIMEOUT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Command fields latched from the winning port at grant time
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [BW-1:0] wtbt;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side and sram-side signals of the arbiter, bundled.
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] req_we;
    logic [AW-1:0]     req_addr0, req_addr1, req_addr2;
    logic [BW-1:0]     req_wtbt0, req_wtbt1, req_wtbt2;
    logic [DW-1:0]     req_din0, req_din1, req_din2;
    logic [NPORTS-1:0] ack;
    logic [DW-1:0]     dout;
    logic              timeout_err;

    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic [BW-1:0]     mem_wtbt;
    logic              mem_we;
    logic              mem_rd;
    logic [DW-1:0]     mem_dout;
    logic              mem_ready;

    // Arbiter view
    modport slave (
        input  req, req_we, req_addr0, req_addr1, req_addr2,
               req_wtbt0, req_wtbt1, req_wtbt2, req_din0, req_din1, req_din2,
               mem_dout, mem_ready,
        output ack, dout, timeout_err, mem_addr, mem_din, mem_wtbt, mem_we, mem_rd
    );

    // Requesters plus sram view
    modport master (
        output req, req_we, req_addr0, req_addr1, req_addr2,
               req_wtbt0, req_wtbt1, req_wtbt2, req_din0, req_din1, req_din2,
               mem_dout, mem_ready,
        input  ack, dout, timeout_err, mem_addr, mem_din, mem_wtbt, mem_we, mem_rd
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: promoted DMA, then CPU, then copy/DMA round-robin.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NPORTS-1:0] i_req,
    input  logic              i_rr_ptr,     // 0 = prefer port 1, 1 = prefer port 2
    input  logic              i_promote,
    output logic [NPORTS-1:0] o_grant_c,
    output logic              o_valid_c
);

    // One-hot grant by fixed priority with round-robin among the lower two
    always_comb begin
        o_grant_c = '0;
        if (i_promote && i_req[P_DMA]) begin
            o_grant_c[P_DMA] = 1'b1;
        end else if (i_req[P_CPU]) begin
            o_grant_c[P_CPU] = 1'b1;
        end else if (i_req[P_COPY] && (!i_rr_ptr || !i_req[P_DMA])) begin
            o_grant_c[P_COPY] = 1'b1;
        end else if (i_req[P_DMA]) begin
            o_grant_c[P_DMA] = 1'b1;
        end
    end

    assign o_valid_c = |i_req;

endmodule

// File: rtl/mem_arbiter.sv
// Three-port arbiter for the single sram word port, one transaction in flight.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned AGE_MAX = 8
) (
    input  logic    clk_sys,
    input  logic    reset,
    mem_arb_if.slave bus
);

    localparam int unsigned TW  = $clog2(TIMEOUT);
    localparam int unsigned AGW = $clog2(AGE_MAX + 1);

    state_e            r_state, w_state_n;
    logic [NPORTS-1:0] r_sel, w_sel_n;
    logic [NPORTS-1:0] r_ack, w_ack_n;
    logic [NPORTS-1:0] w_grant;
    logic              w_valid;
    logic              r_rr_ptr, w_rr_ptr_n;
    logic              r_ready_q;
    logic              w_ready_rise;
    logic              w_win_req;
    logic              w_promote;
    logic [AGW-1:0]    r_age, w_age_n;
    logic [TW-1:0]     r_tcnt, w_tcnt_n;
    logic [DW-1:0]     r_dout, w_dout_n;
    logic              r_terr, w_terr_n;
    mem_cmd_t          r_cmd, w_cmd_n, w_pick_cmd;
    logic              w_pick_we;
    logic              r_mem_we, w_mem_we_n;
    logic              r_mem_rd, w_mem_rd_n;

    assign w_promote    = (r_age == AGW'(AGE_MAX));
    assign w_ready_rise = bus.mem_ready && !r_ready_q;
    assign w_win_req    = |(bus.req & r_sel);

    mem_arb_pick u_pick (
        .i_req     (bus.req),
        .i_rr_ptr  (r_rr_ptr),
        .i_promote (w_promote),
        .o_grant_c (w_grant),
        .o_valid_c (w_valid)
    );

    // Route the winning port's command fields
    always_comb begin
        w_pick_cmd = '0;
        w_pick_we  = 1'b0;
        if (w_grant[P_CPU]) begin
            w_pick_cmd = '{addr: bus.req_addr0, din: bus.req_din0, wtbt: bus.req_wtbt0};
            w_pick_we  = bus.req_we[P_CPU];
        end else if (w_grant[P_COPY]) begin
            w_pick_cmd = '{addr: bus.req_addr1, din: bus.req_din1, wtbt: bus.req_wtbt1};
            w_pick_we  = bus.req_we[P_COPY];
        end else if (w_grant[P_DMA]) begin
            w_pick_cmd = '{addr: bus.req_addr2, din: bus.req_din2, wtbt: bus.req_wtbt2};
            w_pick_we  = bus.req_we[P_DMA];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_n  = r_state;
        w_sel_n    = r_sel;
        w_ack_n    = r_ack;
        w_rr_ptr_n = r_rr_ptr;
        w_age_n    = r_age;
        w_tcnt_n   = r_tcnt;
        w_dout_n   = r_dout;
        w_terr_n   = r_terr;
        w_cmd_n    = r_cmd;
        w_mem_we_n = r_mem_we;
        w_mem_rd_n = r_mem_rd;

        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_sel_n    = w_grant;
                    w_cmd_n    = w_pick_cmd;
                    w_mem_we_n = w_pick_we;
                    w_mem_rd_n = !w_pick_we;
                    w_tcnt_n   = '0;
                    w_state_n  = WAIT;
                    if (w_grant[P_COPY]) w_rr_ptr_n = 1'b1;
                    if (w_grant[P_DMA])  w_rr_ptr_n = 1'b0;
                end
            end
            WAIT: begin
                if (w_ready_rise || (r_tcnt == TW'(TIMEOUT - 1))) begin
                    w_mem_we_n = 1'b0;
                    w_mem_rd_n = 1'b0;
                    if (w_ready_rise) begin
                        if (r_mem_rd) w_dout_n = bus.mem_dout;
                    end else begin
                        w_dout_n = DOUT_TIMEOUT;
                        w_terr_n = 1'b1;
                    end
                    if (w_win_req) begin
                        w_ack_n   = r_sel;
                        w_state_n = HOLD;
                    end else begin
                        w_state_n = IDLE;
                    end
                end else begin
                    w_tcnt_n = r_tcnt + TW'(1);
                end
            end
            HOLD: begin
                if (!w_win_req) begin
                    w_ack_n   = '0;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase

        // DMA aging: count grants it loses while waiting, forget once it leaves
        if (!bus.req[P_DMA]) begin
            w_age_n = '0;
        end else if ((r_state == IDLE) && w_valid) begin
            if (w_grant[P_DMA])                w_age_n = '0;
            else if (r_age != AGW'(AGE_MAX))   w_age_n = r_age + AGW'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_ack     <= '0;
            r_rr_ptr  <= 1'b0;
            r_age     <= '0;
            r_tcnt    <= '0;
            r_dout    <= '0;
            r_terr    <= 1'b0;
            r_cmd     <= '0;
            r_mem_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_ready_q <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_sel     <= w_sel_n;
            r_ack     <= w_ack_n;
            r_rr_ptr  <= w_rr_ptr_n;
            r_age     <= w_age_n;
            r_tcnt    <= w_tcnt_n;
            r_dout    <= w_dout_n;
            r_terr    <= w_terr_n;
            r_cmd     <= w_cmd_n;
            r_mem_we  <= w_mem_we_n;
            r_mem_rd  <= w_mem_rd_n;
            r_ready_q <= bus.mem_ready;
        end
    end

    assign bus.ack         = r_ack;
    assign bus.dout        = r_dout;
    assign bus.timeout_err = r_terr;
    assign bus.mem_addr    = r_cmd.addr;
    assign bus.mem_din     = r_cmd.din;
    assign bus.mem_wtbt    = r_cmd.wtbt;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_rd      = r_mem_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small sram responder.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam logic [23:0] A0 = 24'h00A000;
    localparam logic [23:0] A1 = 24'h111111;
    localparam logic [23:0] A2 = 24'h222222;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    mem_arb_if bus ();

    mem_arbiter #(.TIMEOUT(64), .AGE_MAX(8)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Wait for a grant, then answer with a ready edge after lat control-high cycles
    task automatic serve(input int lat, input logic [15:0] data, input logic abort,
                         output int wait_cyc, output int hi, output int port, output logic was_we);
        wait_cyc = 0;
        while (!(bus.mem_rd || bus.mem_we) && wait_cyc < 50) begin
            step();
            wait_cyc++;
        end
        port   = (bus.mem_addr == A0) ? 0 : (bus.mem_addr == A1) ? 1 : (bus.mem_addr == A2) ? 2 : 7;
        was_we = bus.mem_we;
        hi = 0;
        while ((bus.mem_rd || bus.mem_we) && hi < 200) begin
            hi++;
            if (abort && hi == 1 && port < 3) bus.req[port] = 1'b0;
            if (hi == lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_dout  = data;
            end
            step();
        end
        bus.mem_ready = 1'b0;
    endtask

    // Four-phase release of a port, optionally re-requesting right after
    task automatic release_port(input int p, input logic rereq);
        bus.req[p] = 1'b0;
        step();
        check("ack_clear", 32'(bus.ack), 32'h0);
        if (rereq) bus.req[p] = 1'b1;
    endtask

    initial begin
        int   wc, hi, p;
        logic we;
        int   rr_exp [4]  = '{1, 2, 1, 2};
        int   ct_exp [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 0};

        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr0 = A0;
        bus.req_addr1 = A1;
        bus.req_addr2 = A2;
        bus.req_wtbt0 = 2'b11;
        bus.req_wtbt1 = 2'b11;
        bus.req_wtbt2 = 2'b11;
        bus.req_din0  = 16'h0000;
        bus.req_din1  = 16'h0000;
        bus.req_din2  = 16'h0000;
        bus.mem_dout  = 16'h0000;
        bus.mem_ready = 1'b0;

        do_reset();
        check("rst_ack",  32'(bus.ack), 32'h0);
        check("rst_rd",   32'(bus.mem_rd), 32'h0);
        check("rst_we",   32'(bus.mem_we), 32'h0);
        check("rst_dout", 32'(bus.dout), 32'h0);
        check("rst_terr", 32'(bus.timeout_err), 32'h0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0);

        // Single read on port 0
        bus.req[0] = 1'b1;
        serve(5, 16'h1234, 1'b0, wc, hi, p, we);
        check("rd_latency", 32'(wc), 32'd1);
        check("rd_port", 32'(p), 32'd0);
        check("rd_hi_cycles", 32'(hi), 32'd5);
        check("rd_is_read", 32'(we), 32'd0);
        check("rd_dout", 32'(bus.dout), 32'h1234);
        check("rd_ack", 32'(bus.ack), 32'b001);
        step();
        check("rd_ack_hold", 32'(bus.ack), 32'b001);
        release_port(0, 1'b0);
        step();
        check("rd_idle", 32'({bus.mem_rd, bus.mem_we}), 32'h0);

        // Byte write on port 1
        bus.req_we[1] = 1'b1;
        bus.req_wtbt1 = 2'b10;
        bus.req_din1  = 16'hAB00;
        bus.req[1]    = 1'b1;
        serve(3, 16'hDEAD, 1'b0, wc, hi, p, we);
        check("wr_port", 32'(p), 32'd1);
        check("wr_is_write", 32'(we), 32'd1);
        check("wr_hi_cycles", 32'(hi), 32'd3);
        check("wr_wtbt", 32'(bus.mem_wtbt), 32'b10);
        check("wr_din", 32'(bus.mem_din), 32'hAB00);
        check("wr_dout_kept", 32'(bus.dout), 32'h1234);
        check("wr_ack", 32'(bus.ack), 32'b010);
        release_port(1, 1'b0);
        bus.req_we[1] = 1'b0;

        // Round-robin between ports 1 and 2 from a fresh pointer
        do_reset();
        bus.req = 3'b110;
        for (int i = 0; i < 4; i++) begin
            serve(2, 16'h0100 + 16'(i), 1'b0, wc, hi, p, we);
            check($sformatf("rr_grant%0d", i), 32'(p), 32'(rr_exp[i]));
            if (p < 3) release_port(p, 1'b1);
        end
        bus.req = '0;
        step();
        step();

        // Full contention: CPU wins until DMA ages out
        bus.req = 3'b111;
        for (int i = 0; i < 10; i++) begin
            serve(2, 16'h0200 + 16'(i), 1'b0, wc, hi, p, we);
            check($sformatf("ct_grant%0d", i), 32'(p), 32'(ct_exp[i]));
            if (p < 3) release_port(p, 1'b1);
        end
        bus.req = '0;
        step();
        step();

        // Abort: DMA drops its request mid-transaction
        bus.req[2] = 1'b1;
        serve(4, 16'h5A5A, 1'b1, wc, hi, p, we);
        check("ab_port", 32'(p), 32'd2);
        check("ab_hi_cycles", 32'(hi), 32'd4);
        check("ab_no_ack", 32'(bus.ack), 32'h0);
        check("ab_dout", 32'(bus.dout), 32'h5A5A);
        step();
        check("ab_idle", 32'({bus.ack, bus.mem_rd, bus.mem_we}), 32'h0);

        // Timeout: ready never rises
        bus.req[0] = 1'b1;
        serve(1000, 16'h0000, 1'b0, wc, hi, p, we);
        check("to_hi_cycles", 32'(hi), 32'd64);
        check("to_dout", 32'(bus.dout), 32'hFFFF);
        check("to_err", 32'(bus.timeout_err), 32'h1);
        check("to_ack", 32'(bus.ack), 32'b001);
        release_port(0, 1'b0);
        step();
        check("to_err_sticky", 32'(bus.timeout_err), 32'h1);

        // Reset in the middle of a new transaction
        bus.req[1] = 1'b1;
        wc = 0;
        while (!bus.mem_rd && wc < 50) begin
            step();
            wc++;
        end
        check("mr_granted", 32'(bus.mem_rd), 32'h1);
        step();
        step();
        reset = 1'b1;
        step();
        check("mr_ack",  32'(bus.ack), 32'h0);
        check("mr_ctrl", 32'({bus.mem_rd, bus.mem_we}), 32'h0);
        check("mr_dout", 32'(bus.dout), 32'h0);
        check("mr_terr", 32'(bus.timeout_err), 32'h0);
        check("mr_bus",  32'({bus.mem_din, bus.mem_wtbt}), 32'h0);
        check("mr_addr", 32'(bus.mem_addr), 32'h0);
        bus.req = '0;
        reset   = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
